// File: rtl/lap_record_controller.sv
// Lap timestamp store between the stopwatch control FSM and the LCD driver.
// Optional ring-buffer overwrite when full: define LAP_OVERWRITE_EN.
module lap_record_controller #(
  parameter int TIME_W = 24,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              save_req,
  input  logic              clear_req,
  input  logic [TIME_W-1:0] time_in,
  output logic              busy,
  output logic [ADDR_W:0]   lap_count,
  output logic              full,
  output logic              lcd_req,
  output logic              lcd_clear,
  output logic [ADDR_W-1:0] lcd_addr,
  output logic [TIME_W-1:0] lcd_data,
  input  logic              lcd_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [TIME_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LCD_REQ,
    CLR_SWEEP,
    CLR_LCD
  } state_t;

  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     lap_count_q, lap_count_d;
  logic                full_q, full_d;
  logic                busy_q, busy_d;
  logic                lcd_req_q, lcd_req_d;
  logic                lcd_clear_q, lcd_clear_d;
  logic [ADDR_W-1:0]   lcd_addr_q, lcd_addr_d;
  logic [TIME_W-1:0]   lcd_data_q, lcd_data_d;
  logic [TIME_W-1:0]   slot_q [DEPTH];

  logic                slot_we;
  logic [ADDR_W-1:0]   slot_wa;
  logic [TIME_W-1:0]   slot_wd;
  logic                save_ok;

`ifdef LAP_OVERWRITE_EN
  assign save_ok = 1'b1;
`else
  // A full store drops new saves entirely, so the FSM never leaves IDLE.
  assign save_ok = ~full_q;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wr_ptr_d    = wr_ptr_q;
    idx_d       = idx_q;
    lap_count_d = lap_count_q;
    lcd_req_d   = lcd_req_q;
    lcd_clear_d = lcd_clear_q;
    lcd_addr_d  = lcd_addr_q;
    lcd_data_d  = lcd_data_q;
    slot_we     = 1'b0;
    slot_wa     = wr_ptr_q;
    slot_wd     = hold_q;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLR_SWEEP;
          idx_d   = '0;
        end else if (save_req && save_ok) begin
          hold_d  = time_in;
          state_d = STORE;
        end
      end
      STORE: begin
        slot_we    = 1'b1;
        slot_wa    = wr_ptr_q;
        slot_wd    = hold_q;
        lcd_addr_d = wr_ptr_q;
        lcd_data_d = hold_q;
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr_d   = wr_ptr_q + 1'b1;
        if (lap_count_q != COUNT_MAX) begin
          lap_count_d = lap_count_q + 1'b1;
        end
        lcd_req_d   = 1'b1;
        lcd_clear_d = 1'b0;
        state_d     = LCD_REQ;
      end
      LCD_REQ: begin
        if (lcd_ack) begin
          lcd_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CLR_SWEEP: begin
        slot_we = 1'b1;
        slot_wa = idx_q;
        slot_wd = '0;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          wr_ptr_d    = '0;
          lap_count_d = '0;
          lcd_req_d   = 1'b1;
          lcd_clear_d = 1'b1;
          state_d     = CLR_LCD;
        end
      end
      CLR_LCD: begin
        if (lcd_ack) begin
          lcd_req_d   = 1'b0;
          lcd_clear_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    full_d = (lap_count_d == COUNT_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      idx_q       <= '0;
      lap_count_q <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      lcd_req_q   <= 1'b0;
      lcd_clear_q <= 1'b0;
      lcd_addr_q  <= '0;
      lcd_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      idx_q       <= idx_d;
      lap_count_q <= lap_count_d;
      full_q      <= full_d;
      busy_q      <= busy_d;
      lcd_req_q   <= lcd_req_d;
      lcd_clear_q <= lcd_clear_d;
      lcd_addr_q  <= lcd_addr_d;
      lcd_data_q  <= lcd_data_d;
      if (slot_we) begin
        slot_q[slot_wa] <= slot_wd;
      end
    end
  end

  assign busy      = busy_q;
  assign lap_count = lap_count_q;
  assign full      = full_q;
  assign lcd_req   = lcd_req_q;
  assign lcd_clear = lcd_clear_q;
  assign lcd_addr  = lcd_addr_q;
  assign lcd_data  = lcd_data_q;
  assign rd_data   = slot_q[rd_addr];

endmodule

// File: tb/tb_lap_record_controller.sv
// Self-checking bench for lap_record_controller: transaction model plus directed scenarios.
// Honours LAP_OVERWRITE_EN the same way as the design.
module tb_lap_record_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        save_req = 1'b0;
  logic        clear_req = 1'b0;
  logic [23:0] time_in = '0;
  logic        busy;
  logic [3:0]  lap_count;
  logic        full;
  logic        lcd_req;
  logic        lcd_clear;
  logic [2:0]  lcd_addr;
  logic [23:0] lcd_data;
  logic        lcd_ack = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [23:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  lap_record_controller #(.TIME_W(24), .DEPTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .save_req(save_req), .clear_req(clear_req),
    .time_in(time_in), .busy(busy), .lap_count(lap_count), .full(full),
    .lcd_req(lcd_req), .lcd_clear(lcd_clear), .lcd_addr(lcd_addr),
    .lcd_data(lcd_data), .lcd_ack(lcd_ack), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the store and the LCD request must look like.
  // m_job: 0 nothing pending, 1 lap accepted, 2 lap shown/awaiting LCD, 3 erasing, 4 clear shown.
  int          m_job;
  logic [23:0] m_slot [8];
  logic [23:0] m_hold;
  int          m_wr, m_cnt, m_erased;
  logic        m_req, m_clr;
  int          m_addr;
  logic [23:0] m_data;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_job = 0; m_wr = 0; m_cnt = 0; m_erased = 0;
      m_req = 0; m_clr = 0; m_addr = 0; m_data = '0; m_hold = '0;
      for (int i = 0; i < 8; i++) m_slot[i] = '0;
    end else begin
      case (m_job)
        0: begin
          if (clear_req) begin
            m_job = 3; m_erased = 0;
          end else if (save_req) begin
`ifdef LAP_OVERWRITE_EN
            m_hold = time_in; m_job = 1;
`else
            if (m_cnt < 8) begin m_hold = time_in; m_job = 1; end
`endif
          end
        end
        1: begin
          m_slot[m_wr] = m_hold;
          m_addr = m_wr; m_data = m_hold;
          m_wr = (m_wr + 1) % 8;
          m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
          m_req = 1; m_clr = 0; m_job = 2;
        end
        2: if (lcd_ack) begin m_req = 0; m_job = 0; end
        3: begin
          m_slot[m_erased] = '0;
          m_erased++;
          if (m_erased == 8) begin
            m_wr = 0; m_cnt = 0; m_req = 1; m_clr = 1; m_job = 4;
          end
        end
        default: if (lcd_ack) begin m_req = 0; m_clr = 0; m_job = 0; end
      endcase
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("busy", 32'(busy), 32'(m_job != 0));
      check("lcd_req", 32'(lcd_req), 32'(m_req));
      check("lcd_clear", 32'(lcd_clear), 32'(m_clr));
      check("lap_count", 32'(lap_count), 32'(m_cnt));
      check("full", 32'(full), 32'(m_cnt == 8));
      if (m_req && !m_clr) begin
        check("lcd_addr", 32'(lcd_addr), 32'(m_addr));
        check("lcd_data", 32'(lcd_data), 32'(m_data));
      end
      check("rd_data", 32'(rd_data), 32'(m_slot[rd_addr]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_save(input logic [23:0] t);
    time_in  = t;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (!busy) done = 1;
    end
    if (!done) check("wait_idle_timeout", 32'(1), 32'(0));
    tick();
  endtask

  task automatic read_slot(input string name, input logic [2:0] a, input logic [23:0] exp);
    @(posedge clock);
    #2;
    rd_addr = a;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  int busy_n, req_n, clr_n, wr_n, idle_c, seen_addr;
  bit seen;

  initial begin
    do_reset();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_lcd_req", 32'(lcd_req), 32'(0));
    check("rst_lap_count", 32'(lap_count), 32'(0));

    // 1: save with the LCD answering two cycles after it first samples lcd_req
    lcd_ack = 1'b0;
    pulse_save(24'h000123);
    busy_n = 0; req_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (lcd_req) req_n++;
      if (c == 1) begin
        check("t1_lcd_addr", 32'(lcd_addr), 32'(0));
        check("t1_lcd_data", 32'(lcd_data), 32'h000123);
        check("t1_lcd_clear", 32'(lcd_clear), 32'(0));
      end
      if (c == 4) lcd_ack = 1'b1;
      if (c == 5) lcd_ack = 1'b0;
    end
    check("t1_busy_cycles", 32'(busy_n), 32'(5));
    check("t1_req_cycles", 32'(req_n), 32'(4));
    tick();
    read_slot("t1_slot0", 3'd0, 24'h000123);
    check("t1_lap_count", 32'(lap_count), 32'(1));

    // 2: zero-wait acknowledge; second lap must land in slot 1
    lcd_ack = 1'b1;
    pulse_save(24'h000456);
    busy_n = 0; req_n = 0; idle_c = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (lcd_req) req_n++;
      if (!busy && idle_c < 0) idle_c = c;
      if (c == 1) check("t2_lcd_addr", 32'(lcd_addr), 32'(1));
    end
    check("t2_req_cycles", 32'(req_n), 32'(1));
    check("t2_busy_cycles", 32'(busy_n), 32'(2));
    check("t2_edges_to_idle", 32'(idle_c + 1), 32'(3));
    tick();

    // 3: fill all eight slots, then one more save
    do_reset();
    lcd_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      pulse_save(24'(i));
      wait_idle();
    end
    check("t3_full", 32'(full), 32'(1));
    check("t3_lap_count", 32'(lap_count), 32'(8));
    pulse_save(24'h000009);
    busy_n = 0; seen = 0; seen_addr = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (lcd_req && !seen) begin seen = 1; seen_addr = int'(lcd_addr); end
    end
    tick();
`ifdef LAP_OVERWRITE_EN
    check("t3_ovw_busy_cycles", 32'(busy_n), 32'(2));
    check("t3_ovw_lcd_addr", 32'(seen_addr), 32'(0));
    read_slot("t3_ovw_slot0", 3'd0, 24'h000009);
`else
    check("t3_drop_busy_cycles", 32'(busy_n), 32'(0));
    read_slot("t3_drop_slot0", 3'd0, 24'h000001);
`endif
    check("t3_lap_count_after", 32'(lap_count), 32'(8));
    read_slot("t3_slot7", 3'd7, 24'h000008);

    // 4: clear after three laps
    do_reset();
    lcd_ack = 1'b1;
    pulse_save(24'h000011); wait_idle();
    pulse_save(24'h000022); wait_idle();
    pulse_save(24'h000033); wait_idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_n = 0; clr_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (lcd_req && lcd_clear) clr_n++;
    end
    tick();
    check("t4_busy_cycles", 32'(busy_n), 32'(9));
    check("t4_clear_reqs", 32'(clr_n), 32'(1));
    check("t4_lap_count", 32'(lap_count), 32'(0));
    for (int a = 0; a < 8; a++) read_slot("t4_slot_zero", 3'(a), 24'h0);
    pulse_save(24'h000077);
    @(negedge clock);
    @(negedge clock);
    check("t4_restart_req", 32'(lcd_req), 32'(1));
    check("t4_restart_addr", 32'(lcd_addr), 32'(0));
    wait_idle();
    read_slot("t4_restart_slot0", 3'd0, 24'h000077);

    // 5: save and clear together, then a save in the middle of the sweep
    do_reset();
    lcd_ack = 1'b1;
    pulse_save(24'h000101); wait_idle();
    pulse_save(24'h000202); wait_idle();
    time_in = 24'h000055;
    save_req = 1'b1;
    clear_req = 1'b1;
    tick();
    save_req = 1'b0;
    clear_req = 1'b0;
    wr_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin time_in = 24'h000066; save_req = 1'b1; end
      if (c == 4) save_req = 1'b0;
      @(negedge clock);
      if (lcd_req && !lcd_clear) wr_n++;
    end
    tick();
    check("t5_lap_writes", 32'(wr_n), 32'(0));
    check("t5_lap_count", 32'(lap_count), 32'(0));
    read_slot("t5_slot0", 3'd0, 24'h0);
    read_slot("t5_slot1", 3'd1, 24'h0);

    // 6: reset while a lap request is waiting for the LCD
    lcd_ack = 1'b0;
    pulse_save(24'h000099);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (lcd_req) seen = 1;
    end
    check("t6_req_seen", 32'(seen), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_lcd_req", 32'(lcd_req), 32'(0));
    check("t6_async_busy", 32'(busy), 32'(0));
    check("t6_async_lap_count", 32'(lap_count), 32'(0));
    #4;
    reset = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) read_slot("t6_slot_zero", 3'(a), 24'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
